bsg_counter_set_down_one_hot: RTL and testbench

BSG_COUNTER_SET_DOWN_ONE_HOT -- requirements
Module: bsg_counter_set_down_one_hot

---
 rtl/bsg_counter_set_down_one_hot.sv | 98 +++++++++
 tb/tb_bsg_counter_set_down_one_hot.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_set_down_one_hot.sv
// rtl/bsg_counter_set_down_one_hot.sv - one-hot down counter with load, clamp, done and underflow flags
module bsg_counter_set_down_one_hot #(
    parameter int max_val_p = 32,
    parameter int lg_els_lp = $clog2(max_val_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 set_i,
    input  logic [lg_els_lp-1:0] val_i,
    input  logic                 down_i,
    output logic [max_val_p:0]   count_r_o,
    output logic [lg_els_lp-1:0] count_bin_o,
    output logic                 zero_o,
    output logic                 done_o,
    output logic                 underflow_r_o,
    output logic                 clamp_o
);

    // Largest loadable value expressed at the binary port width.
    localparam logic [lg_els_lp-1:0] max_val_lp = lg_els_lp'(max_val_p);

    logic                 val_over;
    logic [lg_els_lp-1:0] val_eff;
    logic [max_val_p:0]   set_one_hot;
    logic [max_val_p:0]   count_n;
    logic                 underflow_n;
    logic                 done_n;
    logic                 clamp_n;

    // Saturate out-of-range load values to the top count so the decoder
    // below always produces exactly one set bit.
    always_comb begin
        val_over = (val_i > max_val_lp);
        val_eff  = val_over ? max_val_lp : val_i;
    end

    // Binary-to-one-hot decoder for the load path.
    always_comb begin
        set_one_hot = '0;
        for (int k = 0; k <= max_val_p; k++) begin
            set_one_hot[k] = (val_eff == lg_els_lp'(k));
        end
    end

    // Next-state selection: load wins over decrement, decrement over hold.
    // A decrement at zero leaves the count alone (bit0 cannot shift out)
    // and records the underflow instead.
    always_comb begin
        count_n     = count_r_o;
        underflow_n = underflow_r_o;
        done_n      = 1'b0;
        clamp_n     = 1'b0;
        if (set_i) begin
            count_n     = set_one_hot;
            underflow_n = 1'b0;
            clamp_n     = val_over;
        end else if (down_i) begin
            if (count_r_o[0]) begin
                underflow_n = 1'b1;
            end else begin
                count_n = count_r_o >> 1;
                done_n  = count_r_o[1];
            end
        end
    end

    // State and pulse registers; reset returns the count to value zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r_o     <= {{max_val_p{1'b0}}, 1'b1};
            underflow_r_o <= 1'b0;
            done_o        <= 1'b0;
            clamp_o       <= 1'b0;
        end else begin
            count_r_o     <= count_n;
            underflow_r_o <= underflow_n;
            done_o        <= done_n;
            clamp_o       <= clamp_n;
        end
    end

    // One-hot-to-binary encoder: OR together the indices of set bits,
    // which is exact because only one bit is ever set.
    always_comb begin
        count_bin_o = '0;
        for (int k = 0; k <= max_val_p; k++) begin
            if (count_r_o[k]) begin
                count_bin_o = count_bin_o | lg_els_lp'(k);
            end
        end
    end

    // Zero indication straight from the low one-hot bit.
    always_comb begin
        zero_o = count_r_o[0];
    end

endmodule

// File: tb/tb_bsg_counter_set_down_one_hot.sv
// tb/tb_bsg_counter_set_down_one_hot.sv - directed and random checks for bsg_counter_set_down_one_hot
module tb_bsg_counter_set_down_one_hot;

    logic        clk_i;
    logic        reset_n_i;
    logic        set_i;
    logic [5:0]  val_i;
    logic        down_i;
    logic [32:0] count_r_o;
    logic [5:0]  count_bin_o;
    logic        zero_o;
    logic        done_o;
    logic        underflow_r_o;
    logic        clamp_o;

    int pass_cnt;
    int total_cnt;

    bsg_counter_set_down_one_hot dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .set_i         (set_i),
        .val_i         (val_i),
        .down_i        (down_i),
        .count_r_o     (count_r_o),
        .count_bin_o   (count_bin_o),
        .zero_o        (zero_o),
        .done_o        (done_o),
        .underflow_r_o (underflow_r_o),
        .clamp_o       (clamp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        set_i = 1'b1; val_i = 6'd9; down_i = 1'b0;
        step();
        set_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        total_cnt++; if (count_r_o !== 33'h1) $display("FAIL reset_count: got %h want %h", count_r_o, 33'h1); else pass_cnt++;
        total_cnt++; if (zero_o !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero_o); else pass_cnt++;
        total_cnt++; if (count_bin_o !== 6'd0) $display("FAIL reset_bin: got %0d want 0", count_bin_o); else pass_cnt++;
        total_cnt++; if ({done_o, clamp_o, underflow_r_o} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {done_o, clamp_o, underflow_r_o}); else pass_cnt++;
        step();
        reset_n_i = 1'b1;
        step();
        total_cnt++; if (count_r_o !== 33'h1) $display("FAIL reset_idle_hold: got %h want %h", count_r_o, 33'h1); else pass_cnt++;
    endtask

    task automatic test_countdown();
        int done_seen;
        logic [5:0] exp_seq [4];
        exp_seq[0] = 6'd3; exp_seq[1] = 6'd2; exp_seq[2] = 6'd1; exp_seq[3] = 6'd0;
        done_seen = 0;
        set_i = 1'b1; val_i = 6'd3; down_i = 1'b0;
        step();
        set_i = 1'b0; down_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (count_bin_o !== exp_seq[i]) $display("FAIL countdown_bin[%0d]: got %0d want %0d", i, count_bin_o, exp_seq[i]); else pass_cnt++;
            total_cnt++; if (done_o !== (i == 3)) $display("FAIL countdown_done[%0d]: got %b want %b", i, done_o, (i == 3)); else pass_cnt++;
            if (done_o === 1'b1) done_seen++;
            if (i == 2) down_i = 1'b1;
            if (i == 3) down_i = 1'b0;
            if (i < 3) step();
        end
        step();
        if (done_o === 1'b1) done_seen++;
        total_cnt++; if (done_seen !== 1) $display("FAIL countdown_done_count: got %0d want 1", done_seen); else pass_cnt++;
        total_cnt++; if (zero_o !== 1'b1) $display("FAIL countdown_zero: got %b want 1", zero_o); else pass_cnt++;
    endtask

    task automatic test_underflow();
        down_i = 1'b1; set_i = 1'b0;
        step();
        down_i = 1'b0;
        total_cnt++; if (count_r_o !== 33'h1) $display("FAIL underflow_count: got %h want %h", count_r_o, 33'h1); else pass_cnt++;
        total_cnt++; if (underflow_r_o !== 1'b1) $display("FAIL underflow_flag: got %b want 1", underflow_r_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL underflow_done: got %b want 0", done_o); else pass_cnt++;
        step();
        total_cnt++; if (underflow_r_o !== 1'b1) $display("FAIL underflow_sticky: got %b want 1", underflow_r_o); else pass_cnt++;
        set_i = 1'b1; val_i = 6'd5;
        step();
        set_i = 1'b0;
        total_cnt++; if (underflow_r_o !== 1'b0) $display("FAIL underflow_clear: got %b want 0", underflow_r_o); else pass_cnt++;
        total_cnt++; if (count_bin_o !== 6'd5) $display("FAIL underflow_reload: got %0d want 5", count_bin_o); else pass_cnt++;
    endtask

    task automatic test_clamp();
        set_i = 1'b1; val_i = 6'd40; down_i = 1'b0;
        step();
        set_i = 1'b0;
        total_cnt++; if (count_r_o !== 33'h1_0000_0000) $display("FAIL clamp_count: got %h want %h", count_r_o, 33'h1_0000_0000); else pass_cnt++;
        total_cnt++; if (count_bin_o !== 6'd32) $display("FAIL clamp_bin: got %0d want 32", count_bin_o); else pass_cnt++;
        total_cnt++; if (clamp_o !== 1'b1) $display("FAIL clamp_pulse: got %b want 1", clamp_o); else pass_cnt++;
        step();
        total_cnt++; if (clamp_o !== 1'b0) $display("FAIL clamp_pulse_end: got %b want 0", clamp_o); else pass_cnt++;
        set_i = 1'b1; val_i = 6'd32;
        step();
        set_i = 1'b0;
        total_cnt++; if (clamp_o !== 1'b0) $display("FAIL clamp_at_max: got %b want 0", clamp_o); else pass_cnt++;
        down_i = 1'b1;
        step();
        down_i = 1'b0;
        total_cnt++; if (count_bin_o !== 6'd31) $display("FAIL down_from_max: got %0d want 31", count_bin_o); else pass_cnt++;
    endtask

    task automatic test_priority();
        set_i = 1'b1; down_i = 1'b1; val_i = 6'd7;
        step();
        set_i = 1'b0; down_i = 1'b0;
        total_cnt++; if (count_bin_o !== 6'd7) $display("FAIL priority_bin: got %0d want 7", count_bin_o); else pass_cnt++;
        total_cnt++; if (count_r_o !== 33'h80) $display("FAIL priority_onehot: got %h want %h", count_r_o, 33'h80); else pass_cnt++;
    endtask

    task automatic test_reset_mid_countdown();
        set_i = 1'b1; val_i = 6'd1;
        step();
        set_i = 1'b0; down_i = 1'b1;
        #2;
        reset_n_i = 1'b0;
        step();
        total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_abort_done: got %b want 0", done_o); else pass_cnt++;
        total_cnt++; if (count_r_o !== 33'h1) $display("FAIL reset_abort_count: got %h want %h", count_r_o, 33'h1); else pass_cnt++;
        down_i = 1'b0;
        reset_n_i = 1'b1;
        step();
        total_cnt++; if ({done_o, underflow_r_o} !== 2'b00) $display("FAIL reset_abort_after: got %b want 00", {done_o, underflow_r_o}); else pass_cnt++;
    endtask

    task automatic test_invariant();
        int m;
        int v;
        logic uf_e, done_e, clamp_e;
        logic [32:0] oh_e;
        int errs;
        errs = 0;
        m = 0; uf_e = 1'b0;
        reset_n_i = 1'b0;
        #1;
        reset_n_i = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            set_i  = ($urandom_range(0, 9) < 2);
            down_i = ($urandom_range(0, 9) < 6);
            v      = $urandom_range(0, 63);
            val_i  = 6'(v);
            done_e = 1'b0; clamp_e = 1'b0;
            if (set_i) begin
                m = (v > 32) ? 32 : v;
                clamp_e = (v > 32);
                uf_e = 1'b0;
            end else if (down_i) begin
                if (m == 0) uf_e = 1'b1;
                else begin
                    done_e = (m == 1);
                    m = m - 1;
                end
            end
            step();
            oh_e = 33'h1 << m;
            total_cnt++;
            if ($countones(count_r_o) != 1 || count_r_o !== oh_e || count_bin_o !== 6'(m)
                || zero_o !== (m == 0) || underflow_r_o !== uf_e || done_o !== done_e || clamp_o !== clamp_e) begin
                if (errs < 10) $display("FAIL random[%0d]: got oh=%h bin=%0d z=%b uf=%b d=%b cl=%b want oh=%h bin=%0d uf=%b d=%b cl=%b",
                    c, count_r_o, count_bin_o, zero_o, underflow_r_o, done_o, clamp_o, oh_e, m, uf_e, done_e, clamp_e);
                errs++;
            end else pass_cnt++;
        end
        set_i = 1'b0; down_i = 1'b0;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset_n_i = 1'b0; set_i = 1'b0; down_i = 1'b0; val_i = 6'd0;
        step();
        reset_n_i = 1'b1;
        step();
        test_reset();
        test_countdown();
        test_underflow();
        test_clamp();
        test_priority();
        test_reset_mid_countdown();
        test_invariant();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
